alu_ctrl_issue: RTL and testbench

- Producer side of the ALU `alu_op` interface: decodes MIPS-style opcode/funct fields into the 4-bit ALU operation code and operand-routing flags.
- Registers the decoded result in a 2-entry output queue with valid/ready handshakes on both sides.
- Sits between instruction fetch/decode and the execute stage that drives the ALU.

---
 rtl/alu_ctrl_issue.sv | 114 +++++++++++
 tb/tb_alu_ctrl_issue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage: decodes opcode/funct into ALU op + routing flags and queues them.
// Optional macro ALU_CTRL_ILLEGAL_EN adds a stored per-entry out_illegal flag.
module alu_ctrl_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_opcode,
  input  logic [5:0]       in_funct,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_op,
  output logic             out_swap,
  output logic             out_use_imm,
`ifdef ALU_CTRL_ILLEGAL_EN
  output logic             out_illegal,
`endif
  output logic [TAG_W-1:0] out_tag
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0010, OP_AND = 4'b0100,
                         OP_OR  = 4'b0101, OP_XOR = 4'b0110, OP_NOR = 4'b0111,
                         OP_SGT = 4'b1010;

  typedef struct packed {
`ifdef ALU_CTRL_ILLEGAL_EN
    logic             ill;
`endif
    logic [3:0]       op;
    logic             swap;
    logic             imm;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             dec;
  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               push, pop;

  // Unrecognised encodings fall through with the all-zero ADD defaults.
  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    case (in_opcode)
      6'h00: case (in_funct)
        6'h20, 6'h21: dec.op = OP_ADD;
        6'h22, 6'h23: dec.op = OP_SUB;
        6'h24:        dec.op = OP_AND;
        6'h25:        dec.op = OP_OR;
        6'h26:        dec.op = OP_XOR;
        6'h27:        dec.op = OP_NOR;
        6'h2A:        begin dec.op = OP_SGT; dec.swap = 1'b1; end
        default: begin
`ifdef ALU_CTRL_ILLEGAL_EN
          dec.ill = 1'b1;
`endif
        end
      endcase
      6'h08, 6'h09, 6'h23, 6'h2B: begin dec.op = OP_ADD; dec.imm = 1'b1; end
      6'h0C: begin dec.op = OP_AND; dec.imm = 1'b1; end
      6'h0D: begin dec.op = OP_OR;  dec.imm = 1'b1; end
      6'h0E: begin dec.op = OP_XOR; dec.imm = 1'b1; end
      6'h0A: begin dec.op = OP_SGT; dec.imm = 1'b1; dec.swap = 1'b1; end
      6'h04, 6'h05: dec.op = OP_SUB;
      default: begin
`ifdef ALU_CTRL_ILLEGAL_EN
        dec.ill = 1'b1;
`endif
      end
    endcase
  end

  // in_ready looks only at registered state so upstream never sees a path from out_ready.
  assign in_ready  = cnt_q < CNT_W'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_ready && out_valid;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= dec;
    end
  end

  assign out_alu_op  = mem_q[rd_ptr_q].op;
  assign out_swap    = mem_q[rd_ptr_q].swap;
  assign out_use_imm = mem_q[rd_ptr_q].imm;
  assign out_tag     = mem_q[rd_ptr_q].tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign out_illegal = mem_q[rd_ptr_q].ill;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed bench for alu_ctrl_issue; a DEPTH=2 and a DEPTH=4 instance share stimulus via sel.
module tb_alu_ctrl_issue;
  logic       clk, reset_n, sel;
  logic       in_valid, out_ready;
  logic [5:0] in_opcode, in_funct;
  logic [3:0] in_tag;

  logic       a_in_ready, a_out_valid, a_swap, a_imm;
  logic       b_in_ready, b_out_valid, b_swap, b_imm;
  logic [3:0] a_op, a_tag, b_op, b_tag;
  logic       in_ready, out_valid, out_swap, out_use_imm;
  logic [3:0] out_alu_op, out_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  logic       a_ill, b_ill, out_illegal;
`endif

  int errors = 0;
  int checks = 0;

  // Hand-computed decode table: {alu_op, swap, use_imm}
  localparam logic [5:0] OPC [19] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05};
  localparam logic [5:0] FUN [19] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                      6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
  localparam logic [5:0] EXP [19] = '{6'b0000_0_0, 6'b0000_0_0, 6'b0010_0_0, 6'b0010_0_0, 6'b0100_0_0,
                                      6'b0101_0_0, 6'b0110_0_0, 6'b0111_0_0, 6'b1010_1_0, 6'b0000_0_1,
                                      6'b0000_0_1, 6'b0100_0_1, 6'b0101_0_1, 6'b0110_0_1, 6'b1010_1_1,
                                      6'b0000_0_1, 6'b0000_0_1, 6'b0010_0_0, 6'b0010_0_0};

  alu_ctrl_issue #(.DEPTH(2), .TAG_W(4)) u_d2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid & ~sel), .in_ready(a_in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready & ~sel), .out_alu_op(a_op),
    .out_swap(a_swap), .out_use_imm(a_imm),
`ifdef ALU_CTRL_ILLEGAL_EN
    .out_illegal(a_ill),
`endif
    .out_tag(a_tag));

  alu_ctrl_issue #(.DEPTH(4), .TAG_W(4)) u_d4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .in_opcode(in_opcode), .in_funct(in_funct), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready & sel), .out_alu_op(b_op),
    .out_swap(b_swap), .out_use_imm(b_imm),
`ifdef ALU_CTRL_ILLEGAL_EN
    .out_illegal(b_ill),
`endif
    .out_tag(b_tag));

  assign in_ready    = sel ? b_in_ready  : a_in_ready;
  assign out_valid   = sel ? b_out_valid : a_out_valid;
  assign out_alu_op  = sel ? b_op        : a_op;
  assign out_swap    = sel ? b_swap      : a_swap;
  assign out_use_imm = sel ? b_imm       : a_imm;
  assign out_tag     = sel ? b_tag       : a_tag;
`ifdef ALU_CTRL_ILLEGAL_EN
  assign out_illegal = sel ? b_ill       : a_ill;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] tag);
    in_valid = 1'b1; in_opcode = op; in_funct = fn; in_tag = tag;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_funct = '0; in_tag = '0;
    #12;
    checks++;
    if ({out_valid, out_alu_op, out_swap, out_use_imm, out_tag} !== 11'b0) begin
      errors++; $display("FAIL reset_outs got=%b want=0", {out_valid, out_alu_op, out_swap, out_use_imm, out_tag});
    end
`ifdef ALU_CTRL_ILLEGAL_EN
    checks++;
    if (out_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", out_illegal); end
`endif
    reset_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL reset_release got in_ready/out_valid=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_decode_sweep;
    out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(OPC[i], FUN[i], 4'(i));
      tick();
      checks++;
      if ({out_valid, out_alu_op, out_swap, out_use_imm, out_tag} !== {1'b1, EXP[i], 4'(i)}) begin
        errors++;
        $display("FAIL sweep[%0d] got v/op/swap/imm/tag=%b want=%b", i,
                 {out_valid, out_alu_op, out_swap, out_use_imm, out_tag}, {1'b1, EXP[i], 4'(i)});
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain out_valid=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(6'h00, 6'h24, 4'd1); tick();
    drive(6'h00, 6'h25, 4'd2);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_second_ready got=%b want=1", in_ready); end
    tick();
    drive(6'h00, 6'h27, 4'd3);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({in_ready, out_valid, out_alu_op, out_tag} !== {1'b0, 1'b1, 4'b0100, 4'd1}) begin
        errors++; $display("FAIL bp_stall[%0d] got rdy/v/op/tag=%b want=0101000001", c,
                           {in_ready, out_valid, out_alu_op, out_tag});
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_alu_op, out_tag} !== {1'b1, 4'b0101, 4'd2}) begin
      errors++; $display("FAIL bp_pop2 got v/op/tag=%b want=101010010", {out_valid, out_alu_op, out_tag});
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_alu_op, out_tag} !== {1'b1, 4'b0111, 4'd3}) begin
      errors++; $display("FAIL bp_pop3 got v/op/tag=%b want=101110011", {out_valid, out_alu_op, out_tag});
    end
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_empty got rdy/v=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] t;
    out_ready = 1'b0;
    drive(6'h04, 6'h00, 4'd0); tick();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      t = 4'($urandom_range(0, 15));
      drive((k % 2) ? 6'h0D : 6'h04, 6'h00, t);
      tick();
      checks++;
      if ({in_ready, out_valid, out_tag} !== {2'b11, t}) begin
        errors++; $display("FAIL b2b[%0d] got rdy/v/tag=%b want=%b", k, {in_ready, out_valid, out_tag}, {2'b11, t});
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal;
    out_ready = 1'b1;
    drive(6'h3F, 6'h20, 4'd5); tick();
    checks++;
    if ({out_valid, out_alu_op, out_swap, out_use_imm, out_tag} !== {1'b1, 6'b0, 4'd5}) begin
      errors++; $display("FAIL illegal_op got=%b want=10000000101", {out_valid, out_alu_op, out_swap, out_use_imm, out_tag});
    end
`ifdef ALU_CTRL_ILLEGAL_EN
    checks++;
    if (out_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%b want=1", out_illegal); end
`endif
    drive(6'h00, 6'h01, 4'd6); tick();
    checks++;
    if ({out_valid, out_alu_op, out_swap, out_use_imm, out_tag} !== {1'b1, 6'b0, 4'd6}) begin
      errors++; $display("FAIL illegal_funct got=%b want=10000000110", {out_valid, out_alu_op, out_swap, out_use_imm, out_tag});
    end
    drive(6'h0E, 6'h00, 4'd7); tick();
`ifdef ALU_CTRL_ILLEGAL_EN
    checks++;
    if ({out_illegal, out_alu_op} !== 5'b00110) begin
      errors++; $display("FAIL legal_after got ill/op=%b want=00110", {out_illegal, out_alu_op});
    end
`else
    checks++;
    if ({out_alu_op, out_use_imm} !== 5'b01101) begin
      errors++; $display("FAIL legal_after got op/imm=%b want=01101", {out_alu_op, out_use_imm});
    end
`endif
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    drive(6'h00, 6'h25, 4'd9); tick();
    drive(6'h0A, 6'h00, 4'd10); tick();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_alu_op, out_swap, out_use_imm, out_tag} !== 11'b0) begin
      errors++; $display("FAIL midreset_outs got=%b want=0", {out_valid, out_alu_op, out_swap, out_use_imm, out_tag});
    end
    #1 reset_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL midreset_release got rdy/v=%b want=10", {in_ready, out_valid});
    end
    out_ready = 1'b1;
    drive(6'h04, 6'h00, 4'd11); tick();
    checks++;
    if ({out_valid, out_alu_op, out_use_imm, out_tag} !== {1'b1, 4'b0010, 1'b0, 4'd11}) begin
      errors++; $display("FAIL midreset_beq got v/op/imm/tag=%b want=1001001011", {out_valid, out_alu_op, out_use_imm, out_tag});
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_wrap(input logic s);
    logic [9:0] exp_q [$];
    logic [9:0] want;
    int sent, got, k;
    sel = s; sent = 0; got = 0; k = 0;
    for (int cyc = 0; cyc < 300 && got < 9; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 9);
      if (sent < 9) begin
        k = (sent * 2) % 19;
        in_opcode = OPC[k]; in_funct = FUN[k]; in_tag = 4'(sent + 3);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({EXP[k], 4'(sent + 3)});
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h3FF;
        if ({out_alu_op, out_swap, out_use_imm, out_tag} !== want) begin
          errors++; $display("FAIL wrap_d%0d[%0d] got=%b want=%b", s ? 4 : 2, got,
                             {out_alu_op, out_swap, out_use_imm, out_tag}, want);
        end
        got++;
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got != 9) begin errors++; $display("FAIL wrap_d%0d_count got=%0d want=9", s ? 4 : 2, got); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_backpressure();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_wrap(1'b0);
    test_wrap(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
